// File: rtl/read_data_reorder_buffer.sv
// Read-return reorder buffer. Tags are allocated in command order, bursts come back
// tagged in any order, and data is released to the frontend strictly in allocation order.
module read_data_reorder_buffer #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alloc_req,
  output logic                  o_alloc_ready,
  output logic [TAG_WIDTH-1:0]  o_alloc_tag,
  input  logic                  i_ret_valid,
  input  logic [TAG_WIDTH-1:0]  i_ret_tag,
  input  logic [DATA_WIDTH-1:0] i_ret_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
  localparam int unsigned PW    = TAG_WIDTH + 1;

  logic [PW-1:0]         r_alloc_ptr;
  logic [PW-1:0]         r_retire_ptr;
  logic [DEPTH-1:0]      r_filled;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_empty;
  logic                  r_full;
  logic                  r_err;

  logic                  w_alloc_fire;
  logic [TAG_WIDTH-1:0]  w_retire_idx;
  logic                  w_rd_valid;
  logic                  w_retire;
  logic [PW-1:0]         w_count;
  logic [TAG_WIDTH-1:0]  w_ret_off;
  logic                  w_ret_legal;
  logic                  w_ret_illegal;
  logic [PW-1:0]         w_alloc_ptr_nxt;
  logic [PW-1:0]         w_retire_ptr_nxt;
  logic [DEPTH-1:0]      w_filled_nxt;
  logic                  w_empty_nxt;
  logic                  w_full_nxt;

  assign w_alloc_fire  = i_alloc_req && !r_full;
  assign w_retire_idx  = r_retire_ptr[TAG_WIDTH-1:0];
  assign w_rd_valid    = !r_empty && r_filled[w_retire_idx];
  assign w_retire      = w_rd_valid && i_rd_ready;
  assign w_count       = r_alloc_ptr - r_retire_ptr;

  // Modular distance from the head tells whether the returned tag is outstanding.
  assign w_ret_off     = i_ret_tag - w_retire_idx;
  assign w_ret_legal   = i_ret_valid && (PW'(w_ret_off) < w_count) && !r_filled[i_ret_tag];
  assign w_ret_illegal = i_ret_valid && !w_ret_legal;

  assign w_alloc_ptr_nxt  = w_alloc_fire ? r_alloc_ptr + PW'(1) : r_alloc_ptr;
  assign w_retire_ptr_nxt = w_retire ? r_retire_ptr + PW'(1) : r_retire_ptr;
  assign w_empty_nxt      = (w_alloc_ptr_nxt == w_retire_ptr_nxt);
  assign w_full_nxt       = (w_alloc_ptr_nxt[TAG_WIDTH] != w_retire_ptr_nxt[TAG_WIDTH]) &&
                            (w_alloc_ptr_nxt[TAG_WIDTH-1:0] == w_retire_ptr_nxt[TAG_WIDTH-1:0]);

  // A legal return never targets the retiring entry, so clear and set cannot collide.
  always_comb begin
    w_filled_nxt = r_filled;
    if (w_retire)    w_filled_nxt[w_retire_idx] = 1'b0;
    if (w_ret_legal) w_filled_nxt[i_ret_tag]    = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alloc_ptr  <= '0;
      r_retire_ptr <= '0;
      r_filled     <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_alloc_ptr  <= w_alloc_ptr_nxt;
      r_retire_ptr <= w_retire_ptr_nxt;
      r_filled     <= w_filled_nxt;
      r_empty      <= w_empty_nxt;
      r_full       <= w_full_nxt;
      r_err        <= w_ret_illegal;
    end
  end

  // Burst storage is not reset; the filled bits guard it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_ret_legal) r_mem[i_ret_tag] <= i_ret_data;
  end

  assign o_alloc_ready = !r_full;
  assign o_alloc_tag   = r_alloc_ptr[TAG_WIDTH-1:0];
  assign o_rd_valid    = w_rd_valid;
  assign o_rd_data     = r_mem[w_retire_idx];
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_err         = r_err;

endmodule
